// File: rtl/wrrab_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package wrrab_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Index width; a single requester still needs a one-bit index.
    function automatic int ID_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int qnorm(input int w);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/wrrab_rr_pick.sv
// Rotating-priority picker: first requester after 'last', wrapping, with 'last' itself scanned last.
module rr_pick
    import wrrab_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = ID_W(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          found,
    output logic [IW-1:0] pick
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] masked;

    always_comb begin
        dbl    = {req, req};
        masked = '0;
        found  = 1'b0;
        pick   = '0;
        // Keep only the window last+1 .. last+N of the doubled vector.
        for (int i = 0; i < 2 * N; i++) begin
            if (i > int'(last) && i <= int'(last) + N) begin
                masked[i] = dbl[i];
            end
        end
        // Descending scan so the lowest set position wins.
        for (int i = 2 * N - 1; i >= 0; i--) begin
            if (masked[i]) begin
                found = 1'b1;
                pick  = IW'(i % N);
            end
        end
    end

endmodule

// File: rtl/wrrab.sv
// Weighted round-robin arbiter: each holder keeps the grant for up to its quantum before priority rotates.
module wrrab
    import wrrab_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N-1:0]         request,
    input  logic [N*CW-1:0]      weight,
    output logic [N-1:0]         grant,
    output logic [ID_W(N)-1:0]   grant_id,
    output logic                 grant_valid
);

    localparam int IW = ID_W(N);

    state_t         state_q, state_d;
    logic [IW-1:0]  cur_q, cur_d;
    logic [IW-1:0]  id_d;
    logic [CW:0]    cnt_q, cnt_d;
    logic [CW-1:0]  q_q, q_d;
    logic [CW-1:0]  w_pick;
    logic [N-1:0]   grant_d;
    logic           found;
    logic           keep;
    logic [IW-1:0]  pick;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req   (request),
        .last  (cur_q),
        .found (found),
        .pick  (pick)
    );

    assign w_pick = weight[int'(pick)*CW +: CW];
    assign keep   = (state_q == BUSY) && request[cur_q] && (cnt_q < {1'b0, q_q});

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        grant_d = grant;
        id_d    = grant_id;
        if (keep) begin
            cnt_d = cnt_q + (CW+1)'(1);
        end else if (found) begin
            // New tenure: the quantum is latched here so later weight edits wait for the next one.
            state_d       = BUSY;
            cur_d         = pick;
            cnt_d         = (CW+1)'(1);
            q_d           = CW'(qnorm(int'(w_pick)));
            grant_d       = '0;
            grant_d[pick] = 1'b1;
            id_d          = pick;
        end else begin
            state_d = IDLE;
            grant_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cur_q       <= IW'(N - 1);
            cnt_q       <= '0;
            q_q         <= CW'(1);
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            cnt_q       <= cnt_d;
            q_q         <= q_d;
            grant       <= grant_d;
            grant_id    <= id_d;
            grant_valid <= |grant_d;
        end
    end

endmodule

// File: tb/tb_wrrab.sv
// Self-checking bench for wrrab: directed scenarios plus randomized traffic against a tenure-level model.
module tb_wrrab;

    localparam int N  = 4;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    request = '0;
    logic [N*CW-1:0] weight = '0;
    logic [N-1:0]    grant;
    logic [1:0]      grant_id;
    logic            grant_valid;

    int total = 0;
    int bad   = 0;

    // Model: who holds the resource, how many more cycles it may keep it, last holder, last reported id.
    int m_holder;
    int m_left;
    int m_last;
    int m_id;

    always #5 clk = ~clk;

    wrrab #(.N(N), .CW(CW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .request     (request),
        .weight      (weight),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    function automatic void model_reset();
        m_holder = -1;
        m_left   = 0;
        m_last   = N - 1;
        m_id     = 0;
    endfunction

    function automatic void model_step(input logic [N-1:0] req, input logic [N*CW-1:0] wt);
        int w;
        if (m_holder >= 0 && req[m_holder] && m_left > 0) begin
            m_left = m_left - 1;
        end else begin
            m_holder = -1;
            for (int k = 1; k <= N; k++) begin
                if (m_holder < 0 && req[(m_last + k) % N]) m_holder = (m_last + k) % N;
            end
            if (m_holder >= 0) begin
                w = int'(wt[m_holder*CW +: CW]);
                if (w == 0) w = 1;
                m_left = w - 1;
                m_last = m_holder;
                m_id   = m_holder;
            end
        end
    endfunction

    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] g;
        g = '0;
        if (m_holder >= 0) g[m_holder] = 1'b1;
        return g;
    endfunction

    task automatic cycle();
        @(posedge clk);
        if (reset_n) model_step(request, weight);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        request = '1;
        weight  = 16'h1111;
        model_reset();
        #1;
        total++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0) begin
            bad++;
            $display("FAIL reset_async grant=%b valid=%b id=%0d expected 0000/0/0", grant, grant_valid, grant_id);
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0) begin
            bad++;
            $display("FAIL reset_held grant=%b valid=%b id=%0d expected 0000/0/0", grant, grant_valid, grant_id);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset_priority();
        int seq[5];
        seq = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            cycle();
            total++;
            if (grant !== 4'(1 << seq[i]) || grant_id !== 2'(seq[i]) || grant_valid !== 1'b1) begin
                bad++;
                $display("FAIL reset_priority cyc=%0d grant=%b id=%0d expected id %0d", i, grant, grant_id, seq[i]);
            end
        end
    endtask

    task automatic test_weighted_rotation();
        int seq[9];
        seq = '{0, 0, 1, 2, 2, 2, 3, 0, 0};
        apply_reset();
        weight  = 16'h1312;
        request = 4'b1111;
        for (int i = 0; i < 9; i++) begin
            cycle();
            total++;
            if (grant_id !== 2'(seq[i]) || grant !== 4'(1 << seq[i]) || grant_valid !== 1'b1) begin
                bad++;
                $display("FAIL weighted_rotation cyc=%0d id=%0d grant=%b expected id %0d", i, grant_id, grant, seq[i]);
            end
        end
    endtask

    task automatic test_early_release();
        apply_reset();
        weight  = 16'h1511;
        request = 4'b1100;
        for (int i = 0; i < 2; i++) begin
            cycle();
            total++;
            if (grant !== 4'b0100) begin
                bad++;
                $display("FAIL early_release_hold cyc=%0d grant=%b expected 0100", i, grant);
            end
        end
        request = 4'b1000;
        cycle();
        total++;
        if (grant !== 4'b1000 || grant_valid !== 1'b1 || grant_id !== 2'd3) begin
            bad++;
            $display("FAIL early_release_handoff grant=%b valid=%b id=%0d expected 1000/1/3", grant, grant_valid, grant_id);
        end
    endtask

    task automatic test_lone_idle();
        apply_reset();
        weight  = 16'h0020;
        request = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            cycle();
            total++;
            if (grant !== 4'b0010 || grant_valid !== 1'b1) begin
                bad++;
                $display("FAIL lone_hold cyc=%0d grant=%b valid=%b expected 0010/1", i, grant, grant_valid);
            end
        end
        request = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            cycle();
            total++;
            if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd1) begin
                bad++;
                $display("FAIL idle cyc=%0d grant=%b valid=%b id=%0d expected 0000/0/1", i, grant, grant_valid, grant_id);
            end
        end
        request = 4'b0001;
        cycle();
        total++;
        if (grant !== 4'b0001 || grant_id !== 2'd0 || grant_valid !== 1'b1) begin
            bad++;
            $display("FAIL idle_wake grant=%b id=%0d expected 0001/0", grant, grant_id);
        end
    endtask

    task automatic test_weight_change();
        int seq[7];
        seq = '{0, 2, 2, 2, 0, 2, 0};
        apply_reset();
        weight  = 16'h1310;
        request = 4'b0101;
        for (int i = 0; i < 7; i++) begin
            cycle();
            if (i == 1) weight = 16'h1110;
            total++;
            if (grant_id !== 2'(seq[i]) || grant !== 4'(1 << seq[i])) begin
                bad++;
                $display("FAIL weight_change cyc=%0d id=%0d grant=%b expected id %0d", i, grant_id, grant, seq[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        weight  = 16'h1111;
        request = 4'b0100;
        cycle();
        total++;
        if (grant !== 4'b0100) begin
            bad++;
            $display("FAIL async_setup grant=%b expected 0100", grant);
        end
        request = 4'b1111;
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0) begin
            bad++;
            $display("FAIL async_clear grant=%b valid=%b id=%0d expected 0000/0/0", grant, grant_valid, grant_id);
        end
        @(negedge clk);
        reset_n = 1'b1;
        cycle();
        total++;
        if (grant !== 4'b0001 || grant_id !== 2'd0) begin
            bad++;
            $display("FAIL async_restart grant=%b id=%0d expected 0001/0", grant, grant_id);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] req_s;
        apply_reset();
        weight  = 16'($urandom);
        request = 4'($urandom_range(0, 15));
        for (int i = 0; i < 600; i++) begin
            req_s = request;
            cycle();
            total++;
            if (grant !== exp_grant() || grant_id !== 2'(m_id) || grant_valid !== (m_holder >= 0)) begin
                bad++;
                $display("FAIL random cyc=%0d grant=%b id=%0d valid=%b expected %b/%0d", i, grant, grant_id, grant_valid, exp_grant(), m_id);
            end
            total++;
            if ((grant & ~req_s) !== 4'b0000) begin
                bad++;
                $display("FAIL random_no_request cyc=%0d grant=%b request=%b", i, grant, req_s);
            end
            if ($urandom_range(0, 9) < 3) request = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 9) == 0) request[$urandom_range(0, N-1)] ^= 1'b1;
            if ($urandom_range(0, 19) == 0) weight = 16'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                reset_n = 1'b0;
                model_reset();
                #1;
                total++;
                if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL random_reset cyc=%0d grant=%b valid=%b expected 0000/0", i, grant, grant_valid);
                end
                @(negedge clk);
                reset_n = 1'b1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_reset_priority();
        test_weighted_rotation();
        test_early_release();
        test_lone_idle();
        test_weight_change();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wrrab.md
# wrrab

Parametrised weighted round-robin arbiter: the next generation of the 2-requester `rrab`. It arbitrates N requesters onto one shared resource. A granted requester may hold the resource for up to a per-requester quantum of consecutive cycles before priority rotates. It sits in front of shared buses and memory ports where fairness with bandwidth shaping is required.

## Interface
- `N`, default 4: number of requesters, must be ≥ 2.
- `CW`, default 4: width of each weight/quantum field.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `request`, input, N: request vector, one bit per requester, level-sensitive.
- `weight`, input, N*CW: per-requester quantum.
  - Field i is `weight[i*CW +: CW]`.
  - A value of 0 is treated as 1.
- `grant`, output, N: registered one-hot grant, or all-zero.
- `grant_id`, output, $clog2(N): binary index of the granted requester; holds its last value when idle.
- `grant_valid`, output, 1: high when `grant` is non-zero.

## Operation
- State:
  - `cur`: index of the current or last holder.
  - `cnt`: cycles already granted to `cur` in this tenure, CW+1 bits.
  - `q`: latched quantum for the current tenure.
  - FSM with two states, IDLE and BUSY.
- Reset (async assert): IDLE; `grant`=0, `grant_valid`=0, `grant_id`=0, `cur`=N-1, `cnt`=0, `q`=1. With `cur`=N-1, requester 0 has first priority after reset.
- Keep condition: BUSY and `request[cur]`=1 and `cnt` < `q`. Every edge then evaluates:
  - If keep is true: stay BUSY, `grant` unchanged, `cnt` += 1.
  - Otherwise, pick the first requesting index scanning circularly from `cur+1` to `cur+N`.
    - `cur` itself is last in the scan, so a lone requester that has exhausted its quantum is re-granted immediately.
    - If a requester is found: BUSY; `grant`=onehot(pick), `cur`=pick, `cnt`=1, `q`=max(weight[pick],1).
    - If none: IDLE; `grant`=0; `cur` and `grant_id` retained.
- Release: when the holder drops `request`, its grant is removed at the edge that samples it low. The next requester is granted at that same edge, with no bubble cycle.
- Weight changes take effect only at the start of a new tenure; mid-tenure changes are ignored.
- `q` = 2^CW−1 gives a maximum tenure of 15 cycles at CW=4. `cnt` never wraps because it saturates at `q`.
- Reset asserted mid-tenure: outputs clear immediately (asynchronously). The first grant after reset release follows the reset priority, requester 0 first.

## Timing
- Latency: `request` sampled at edge k gives `grant` valid after edge k, i.e. 1 cycle registered.
- `grant`, `grant_id` and `grant_valid` all come directly from flops and change together.
- Maximum continuous grant to one requester while others wait: `q` cycles.
- Worst-case wait for a continuously requesting input: sum of the other N−1 quanta.
- `grant` is never asserted to an index whose `request` was 0 at the sampling edge.

## Structure
- Package `wrrab_pkg`:
  - `ID_W` function, defined as `$clog2(N)`.
  - State enum {IDLE, BUSY}.
  - Quantum helper `qnorm(w)`, returning `w==0 ? 1 : w`.
- Sub-module `rr_pick`: combinational rotate-priority picker.
  - Inputs: `req[N]`, `last[ID_W]`.
  - Outputs: `found`, `pick[ID_W]`.
  - Method: double-width masked priority encode.
- Top level holds the FSM, counters and output registers.

## Test plan
- Reset priority: N=4, all weights 1, reset released with `request`=1111 → grants 0,1,2,3,0 on successive cycles; all outputs 0 during reset.
- Weighted rotation: weights {0:2, 1:1, 2:3, 3:1}, `request`=1111 held → grant_id sequence 0,0,1,2,2,2,3,0,0.
- Early release: holder 2 with weight 5 drops `request` after 2 cycles while `request[3]`=1 → grant moves to 3 at that same edge, with no idle cycle.
- Lone requester and idle: only `request[1]`=1 with weight 2 → grant held continuously (re-grant, `cnt` restarts at 1). Then `request`=0000 → `grant_valid`=0 at the next edge, `grant_id` stays 1, next `request`=0001 grants 0.
- Weight 0 and mid-tenure change: weight[0]=0 → 1-cycle tenure. weight[2] changed from 3 to 1 mid-tenure → the current tenure still lasts 3 cycles.
- Async reset mid-tenure: assert `reset_n`=0 between edges while grant=0100 → `grant`=0 immediately; after release with `request`=1111 → first grant 0001.
